// File: rtl/bp_stream_to_lite_pkg.sv
// Shared types and header layout helpers for the stream-to-lite converter.
// The header is packed as {payload, size, addr, subop, msg_type}, with msg_type in the LSBs.
package bp_stream_to_lite_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg      = 2'd0,
    e_bp_unicore_half_cfg = 2'd1
  } bp_params_e;

  localparam int msg_type_width_gp = 4;
  localparam int subop_width_gp    = 4;
  localparam int size_width_gp     = 3;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bedrock_msg_type_e;

  // Physical address width for a processor configuration.
  function automatic int paddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_unicore_half_cfg: return 39;
      default:               return 40;
    endcase
  endfunction

  // Total header width for a configuration and payload width.
  function automatic int header_width(bp_params_e cfg, int payload_width);
    return payload_width + size_width_gp + paddr_width(cfg) + subop_width_gp + msg_type_width_gp;
  endfunction

  // Beats a message occupies on the narrow side: at least one, more only for
  // data-carrying messages wider than a beat.
  function automatic int expected_beats(logic has_data, logic [2:0] size, int beat_bytes);
    int msg_bytes;
    msg_bytes = 1 << size;
    if (!has_data) return 1;
    if (msg_bytes <= beat_bytes) return 1;
    return msg_bytes / beat_bytes;
  endfunction

endpackage

// File: rtl/bp_stream_to_lite_counter.sv
// Beat counter: clear takes priority over up; the count holds at max_val_p
// rather than wrapping so an over-long message cannot alias slot 0.
module bsg_counter_clear_up #(
  parameter int max_val_p = 1,
  parameter int width_p   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               up,
  output logic [width_p-1:0] count
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  // Count accepted beats, cleared at message boundaries and on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (up && (count != max_lp)) begin
      count <= count + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_stream_to_lite.sv
// Collects narrow stream beats of a BedRock message into one wide lite message.
// Both sides use ready-valid-and: a transfer happens on a rising edge where
// valid and ready are both high; valid never depends on ready, and ready here
// depends only on registered state (plus reset), so there is no comb path
// from either input valid to the opposite side.
module bp_stream_to_lite
  import bp_stream_to_lite_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter in_data_width_p  = "inv",
  parameter out_data_width_p = "inv",
  parameter payload_width_p  = "inv",
  parameter payload_mask_p   = 0,
  localparam int paddr_width_lp         = paddr_width(bp_params_p),
  localparam int in_msg_header_width_lp = header_width(bp_params_p, payload_width_p),
  localparam int out_msg_width_lp       = in_msg_header_width_lp + out_data_width_p
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
  input  logic [in_data_width_p-1:0]        in_msg_data_i,
  input  logic                              in_msg_v_i,
  output logic                              in_msg_ready_and_o,
  input  logic                              in_msg_last_i,
  output logic [out_msg_width_lp-1:0]       out_msg_o,
  output logic                              out_msg_v_o,
  input  logic                              out_msg_ready_and_i,
  output logic [1:0]                        debug_state
);

  typedef enum logic [1:0] {
    e_ready   = 2'd0,
    e_collect = 2'd1,
    e_out     = 2'd2
  } state_e;

  localparam int slots_lp     = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = (slots_lp > 1) ? $clog2(slots_lp) : 1;
  localparam int in_bytes_lp  = in_data_width_p / 8;
  localparam int out_bytes_lp = out_data_width_p / 8;
  localparam int size_lsb_lp  = msg_type_width_gp + subop_width_gp + paddr_width_lp;
  // One mask bit per possible msg_type code.
  localparam logic [15:0] payload_mask_lp = payload_mask_p[15:0];

  state_e state_r, state_n;
  logic in_fire, out_fire;
  logic [in_msg_header_width_lp-1:0]           header_r;
  logic [slots_lp-1:0][in_data_width_p-1:0]    data_r;
  logic [cnt_width_lp-1:0]                     beat_cnt;
  logic [msg_type_width_gp-1:0]                msg_type;
  logic [size_width_gp-1:0]                    msg_size;
  logic                                        has_data;
  logic [31:0]                                 msg_bytes;
  logic [31:0]                                 rep_mask;
  logic [out_data_width_p-1:0]                 assembled;
  logic [out_data_width_p-1:0]                 out_data;

  assign in_msg_ready_and_o = reset_n_i & (state_r != e_out);
  assign out_msg_v_o        = (state_r == e_out);
  assign in_fire            = in_msg_v_i & in_msg_ready_and_o;
  assign out_fire           = out_msg_v_o & out_msg_ready_and_i;
  assign debug_state        = state_r;

  // State register; reset drops any partial or pending message.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= e_ready;
    else            state_r <= state_n;
  end

  // Next-state: last beat closes the message, lite handshake reopens input.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:   if (in_fire) state_n = in_msg_last_i ? e_out : e_collect;
      e_collect: if (in_fire && in_msg_last_i) state_n = e_out;
      e_out:     if (out_fire) state_n = e_ready;
      default:   state_n = e_ready;
    endcase
  end

  // Header is taken from the first beat only; later beat headers are ignored.
  always_ff @(posedge clk_i) begin
    if (in_fire && (state_r == e_ready)) header_r <= in_msg_header_i;
  end

  // Each accepted beat lands in the slot selected by the beat counter.
  always_ff @(posedge clk_i) begin
    if (in_fire) data_r[beat_cnt] <= in_msg_data_i;
  end

  bsg_counter_clear_up #(
    .max_val_p(slots_lp - 1),
    .width_p  (cnt_width_lp)
  ) beat_counter (
    .clk    (clk_i),
    .reset_n(reset_n_i),
    .clear  (in_fire & in_msg_last_i),
    .up     (in_fire & ~in_msg_last_i),
    .count  (beat_cnt)
  );

  assign msg_type  = header_r[0 +: msg_type_width_gp];
  assign msg_size  = header_r[size_lsb_lp +: size_width_gp];
  assign has_data  = payload_mask_lp[msg_type];
  assign msg_bytes = 32'd1 << msg_size;
  // Byte-index mask: messages narrower than the lite width wrap onto their own bytes.
  assign rep_mask  = ((msg_bytes < 32'(out_bytes_lp)) ? msg_bytes : 32'(out_bytes_lp)) - 32'd1;
  assign assembled = data_r;

  // Build the lite data: replicate short messages, zero for dataless ones.
  always_comb begin
    out_data = '0;
    if (has_data) begin
      for (int j = 0; j < out_bytes_lp; j++) begin
        out_data[8*j +: 8] = assembled[8*(j & rep_mask) +: 8];
      end
    end
  end

  assign out_msg_o = {header_r, out_data};

  // Beat-count expectation for the message currently being collected.
  logic [msg_type_width_gp-1:0] cur_type;
  logic [size_width_gp-1:0]     cur_size;
  int                           exp_beats;
  int                           beats_seen;

  assign cur_type   = (state_r == e_ready) ? in_msg_header_i[0 +: msg_type_width_gp] : msg_type;
  assign cur_size   = (state_r == e_ready) ? in_msg_header_i[size_lsb_lp +: size_width_gp] : msg_size;
  assign exp_beats  = expected_beats(payload_mask_lp[cur_type], cur_size, in_bytes_lp);
  assign beats_seen = int'(beat_cnt) + 1;

  // The lite side must be an integer multiple of the stream side.
  assert property (@(posedge clk_i)
    (out_data_width_p >= in_data_width_p) && ((out_data_width_p % in_data_width_p) == 0));

  // last must coincide exactly with the expected final beat.
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (in_fire && in_msg_last_i) |-> (beats_seen == exp_beats));

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (in_fire && !in_msg_last_i) |-> (beats_seen < exp_beats));

endmodule
